// File: rtl/simon_pkg.sv
// Shared constants, the Z4 round-constant sequence and FSM state type for the
// Simon-128/256 key schedule.
package simon_pkg;

    localparam int SIMON_WORD_W    = 64;
    localparam int SIMON_KEY_WORDS = 4;
    localparam int SIMON_ROUNDS    = 72;

    // Z4[0] is the leftmost bit of the literal, matching the Simon paper's ordering.
    localparam logic [61:0] SIMON_Z4 =
        62'b11010001111001101011011000100000010111000011001010010011101111;

    typedef enum logic [1:0] {
        KS_IDLE   = 2'd0,
        KS_LOAD   = 2'd1,
        KS_EXPAND = 2'd2,
        KS_FIN    = 2'd3
    } ks_state_t;

    function automatic logic z4_bit(input logic [5:0] idx);
        return SIMON_Z4[6'd61 - idx];
    endfunction

endpackage

// File: rtl/simon_ks_round.sv
// One Simon key-expansion step for m=4:
// (k[i-1], k[i-3], k[i-4], z) -> k[i].
module simon_ks_round
    import simon_pkg::*;
#(
    parameter int WORD_W = SIMON_WORD_W
) (
    input  logic [WORD_W-1:0] k_m1,
    input  logic [WORD_W-1:0] k_m3,
    input  logic [WORD_W-1:0] k_m4,
    input  logic              zbit,
    output logic [WORD_W-1:0] k_new
);

    logic [WORD_W-1:0] tmp_a_s;
    logic [WORD_W-1:0] tmp_b_s;
    logic [WORD_W-1:0] const_s;

    // Rotate, mix and fold in the round constant (z in bit 0, then XOR with 3).
    always_comb begin
        tmp_a_s = {k_m1[2:0], k_m1[WORD_W-1:3]} ^ k_m3;
        tmp_b_s = tmp_a_s ^ {tmp_a_s[0], tmp_a_s[WORD_W-1:1]};
        const_s = {{(WORD_W-2){1'b0}}, 1'b1, ~zbit};
        k_new   = ~k_m4 ^ tmp_b_s ^ const_s;
    end

endmodule

// File: rtl/simon_key_sched_ctrl.sv
// Simon-128/256 key-schedule sequencer: writes 72 round keys into the round-key RAM
// on a start edge. Define SIMON_KS_DROP_CNT_EN to add the dropped_starts counter.
module simon_key_sched_ctrl
    import simon_pkg::*;
#(
    parameter int WORD_W    = SIMON_WORD_W,
    parameter int KEY_WORDS = SIMON_KEY_WORDS,
    parameter int ROUNDS    = SIMON_ROUNDS,
    parameter int ADDR_W    = 7
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [KEY_WORDS*WORD_W-1:0] init_key,
    input  logic                        key_compute_start,
    output logic                        rk_we,
    output logic [ADDR_W-1:0]           rk_addr,
    output logic [WORD_W-1:0]           rk_wdata,
    output logic                        busy,
    output logic                        keys_ready,
    output logic                        done
`ifdef SIMON_KS_DROP_CNT_EN
    ,
    output logic [7:0]                  dropped_starts
`endif
);

    localparam logic [ADDR_W-1:0] LOAD_LAST = ADDR_W'(KEY_WORDS - 1);
    localparam logic [ADDR_W-1:0] LAST_RND  = ADDR_W'(ROUNDS - 1);

    ks_state_t         state_r;
    logic [WORD_W-1:0] sr_r [0:3];
    logic [ADDR_W-1:0] rnd_r;
    logic [5:0]        zidx_r;
    logic              start_q_r;

    logic              start_rise_s;
    logic [ADDR_W-1:0] rnd_inc_s;
    logic [1:0]        load_idx_s;
    logic [5:0]        zidx_nxt_s;
    logic [WORD_W-1:0] next_k_s;

    // Start edge detect and counter increments.
    always_comb begin
        start_rise_s = key_compute_start & ~start_q_r;
        rnd_inc_s    = rnd_r + ADDR_W'(1);
        load_idx_s   = rnd_r[1:0] + 2'd1;
        if (zidx_r == 6'd61) begin
            zidx_nxt_s = 6'd0;
        end else begin
            zidx_nxt_s = zidx_r + 6'd1;
        end
    end

    // sr_r[3] is the newest word k[i-1]; sr_r[0] the oldest k[i-4].
    simon_ks_round #(.WORD_W(WORD_W)) u_round (
        .k_m1  (sr_r[3]),
        .k_m3  (sr_r[1]),
        .k_m4  (sr_r[0]),
        .zbit  (z4_bit(zidx_r)),
        .k_new (next_k_s)
    );

    // Schedule FSM; outputs describe the write presented during the current state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= KS_IDLE;
            rnd_r      <= '0;
            zidx_r     <= 6'd0;
            start_q_r  <= 1'b0;
            rk_we      <= 1'b0;
            rk_addr    <= '0;
            rk_wdata   <= '0;
            busy       <= 1'b0;
            keys_ready <= 1'b0;
            done       <= 1'b0;
            for (int w = 0; w < 4; w++) begin
                sr_r[w] <= '0;
            end
        end else begin
            start_q_r <= key_compute_start;
            case (state_r)
                KS_IDLE: begin
                    rk_we <= 1'b0;
                    done  <= 1'b0;
                    if (start_rise_s) begin
                        for (int w = 0; w < 4; w++) begin
                            sr_r[w] <= init_key[w*WORD_W +: WORD_W];
                        end
                        rk_we      <= 1'b1;
                        rk_addr    <= '0;
                        rk_wdata   <= init_key[WORD_W-1:0];
                        busy       <= 1'b1;
                        keys_ready <= 1'b0;
                        rnd_r      <= '0;
                        zidx_r     <= 6'd0;
                        state_r    <= KS_LOAD;
                    end
                end
                KS_LOAD: begin
                    rk_we   <= 1'b1;
                    rk_addr <= rnd_inc_s;
                    rnd_r   <= rnd_inc_s;
                    if (rnd_r == LOAD_LAST) begin
                        // Leaving LOAD: first computed key goes out, window starts sliding.
                        rk_wdata <= next_k_s;
                        sr_r[0]  <= sr_r[1];
                        sr_r[1]  <= sr_r[2];
                        sr_r[2]  <= sr_r[3];
                        sr_r[3]  <= next_k_s;
                        zidx_r   <= zidx_nxt_s;
                        state_r  <= KS_EXPAND;
                    end else begin
                        rk_wdata <= sr_r[load_idx_s];
                    end
                end
                KS_EXPAND: begin
                    if (rnd_r == LAST_RND) begin
                        rk_we      <= 1'b0;
                        busy       <= 1'b0;
                        keys_ready <= 1'b1;
                        done       <= 1'b1;
                        state_r    <= KS_FIN;
                    end else begin
                        rk_we    <= 1'b1;
                        rk_addr  <= rnd_inc_s;
                        rk_wdata <= next_k_s;
                        rnd_r    <= rnd_inc_s;
                        sr_r[0]  <= sr_r[1];
                        sr_r[1]  <= sr_r[2];
                        sr_r[2]  <= sr_r[3];
                        sr_r[3]  <= next_k_s;
                        zidx_r   <= zidx_nxt_s;
                    end
                end
                KS_FIN: begin
                    rk_we   <= 1'b0;
                    done    <= 1'b0;
                    state_r <= KS_IDLE;
                end
                default: begin
                    rk_we   <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_r <= KS_IDLE;
                end
            endcase
        end
    end

`ifdef SIMON_KS_DROP_CNT_EN
    // Saturating count of start edges rejected because a schedule was running.
    always_ff @(posedge clk) begin
        if (rst) begin
            dropped_starts <= 8'd0;
        end else if (start_rise_s && busy && (dropped_starts != 8'hFF)) begin
            dropped_starts <= dropped_starts + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_simon_key_sched_ctrl.sv
// Bench for simon_key_sched_ctrl: random keys checked against an array-based
// reference schedule, plus latency, hold, mid-run start, reset and back-to-back cases.
module tb_simon_key_sched_ctrl;

    logic         clk;
    logic         rst;
    logic [255:0] init_key;
    logic         key_compute_start;
    logic         rk_we;
    logic [6:0]   rk_addr;
    logic [63:0]  rk_wdata;
    logic         busy;
    logic         keys_ready;
    logic         done;
`ifdef SIMON_KS_DROP_CNT_EN
    logic [7:0]   dropped_starts;
`endif

    simon_key_sched_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .init_key          (init_key),
        .key_compute_start (key_compute_start),
        .rk_we             (rk_we),
        .rk_addr           (rk_addr),
        .rk_wdata          (rk_wdata),
        .busy              (busy),
        .keys_ready        (keys_ready),
        .done              (done)
`ifdef SIMON_KS_DROP_CNT_EN
        ,
        .dropped_starts    (dropped_starts)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_edge = -1;
    logic [6:0]  wa_q[$];
    logic [63:0] wd_q[$];
    int          we_q[$];
    logic [63:0] mk [0:71];

    localparam logic [61:0] Z_SEQ =
        62'b11010001111001101011011000100000010111000011001010010011101111;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ror(input logic [63:0] x, input int s);
        return (x >> s) | (x << (64 - s));
    endfunction

    // Reference schedule straight from the key-expansion equations.
    task automatic build_model(input logic [255:0] key);
        logic [63:0] t;
        logic [63:0] z;
        for (int i = 0; i < 4; i++) mk[i] = key[64*i +: 64];
        for (int i = 4; i < 72; i++) begin
            t = ror(mk[i-1], 3) ^ mk[i-3];
            t = t ^ ror(t, 1);
            z = 64'(Z_SEQ[61 - ((i - 4) % 62)]);
            mk[i] = ~mk[i-4] ^ t ^ z ^ 64'd3;
        end
    endtask

    always @(posedge clk) cyc = cyc + 1;

    // Record each write with the clock edge that commits it to the RAM.
    always @(negedge clk) begin
        if (rk_we) begin
            wa_q.push_back(rk_addr);
            wd_q.push_back(rk_wdata);
            we_q.push_back(cyc + 1);
        end
        if (done) begin
            done_cnt  = done_cnt + 1;
            done_edge = cyc + 1;
        end
    end

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        we_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [255:0] rand_key();
        logic [255:0] k;
        for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
        return k;
    endfunction

    // edge_n = clock edge at which start_rise should be sampled (0 = next edge).
    task automatic start_at(input int edge_n, input logic [255:0] key, input int hold, output int n);
        while (cyc + 1 < edge_n) @(negedge clk);
        init_key = key;
        key_compute_start = 1'b1;
        n = cyc + 1;
        repeat (hold) @(negedge clk);
        key_compute_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0;
        d0 = done_cnt;
        for (int k = 0; k < budget && done_cnt == d0; k++) @(negedge clk);
        chk({tag, "_done_seen"}, 64'(done_cnt != d0), 64'd1);
    endtask

    task automatic verify(input string tag, input int n0);
        chk({tag, "_nwrites"}, 64'(wa_q.size()), 64'd72);
        for (int i = 0; i < wa_q.size() && i < 72; i++) begin
            chk($sformatf("%s_addr%0d", tag, i), 64'(wa_q[i]), 64'(i));
            chk($sformatf("%s_data%0d", tag, i), wd_q[i], mk[i]);
        end
        if (we_q.size() > 0) begin
            chk({tag, "_first_wr_edge"}, 64'(we_q[0]), 64'(n0 + 1));
            chk({tag, "_last_wr_edge"}, 64'(we_q[we_q.size()-1]), 64'(n0 + 72));
        end
        chk({tag, "_done_edge"}, 64'(done_edge), 64'(n0 + 73));
    endtask

    initial begin
        logic [255:0] ka;
        logic [255:0] kb;
        int n;
        int nx;
        int d0;
        clk = 1'b0;
        rst = 1'b1;
        init_key = '0;
        key_compute_start = 1'b0;
        do_reset();

        // Reset state
        chk("rst_we", 64'(rk_we), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(keys_ready), 64'd0);
        chk("rst_done", 64'(done), 64'd0);

        // Reference key vector
        ka = 256'h1f1e1d1c1b1a1918_1716151413121110_0f0e0d0c0b0a0908_0706050403020100;
        build_model(ka);
        clear_log();
        start_at(0, ka, 1, n);
        wait_done("tv", 200);
        verify("tv", n);
        if (wd_q.size() >= 67) begin
            chk("tv_k0", wd_q[0], 64'h0706050403020100);
            chk("tv_k1", wd_q[1], 64'h0f0e0d0c0b0a0908);
            chk("tv_k2", wd_q[2], 64'h1716151413121110);
            chk("tv_k3", wd_q[3], 64'h1f1e1d1c1b1a1918);
            chk("zwrap_k65", wd_q[65], mk[65]);
            chk("zwrap_k66", wd_q[66], mk[66]);
        end
        @(negedge clk);
        chk("tv_ready", 64'(keys_ready), 64'd1);
        chk("tv_busy", 64'(busy), 64'd0);

        // Start held high for 200 cycles: one schedule only
        ka = rand_key();
        build_model(ka);
        clear_log();
        d0 = done_cnt;
        start_at(0, ka, 200, n);
        chk("hold_done_cnt", 64'(done_cnt - d0), 64'd1);
        chk("hold_ready", 64'(keys_ready), 64'd1);
        verify("hold", n);
        @(negedge clk);

        // Second start mid-schedule with another key is ignored
        do_reset();
        ka = rand_key();
        kb = rand_key();
        build_model(ka);
        clear_log();
        d0 = done_cnt;
        start_at(0, ka, 1, n);
        repeat (4) @(negedge clk);
        chk("mid_busy", 64'(busy), 64'd1);
        chk("mid_ready", 64'(keys_ready), 64'd0);
        start_at(n + 30, kb, 1, nx);
        wait_done("mid", 200);
        repeat (100) @(negedge clk);
        chk("mid_done_cnt", 64'(done_cnt - d0), 64'd1);
        verify("mid", n);
`ifdef SIMON_KS_DROP_CNT_EN
        chk("mid_dropped", 64'(dropped_starts), 64'd1);
`endif

        // Reset in the middle of a schedule, then a clean restart
        ka = rand_key();
        start_at(0, ka, 1, n);
        while (cyc + 1 < n + 40) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_we", 64'(rk_we), 64'd0);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_ready", 64'(keys_ready), 64'd0);
        clear_log();
        d0 = done_cnt;
        repeat (100) @(negedge clk);
        chk("rst_mid_nowrites", 64'(wa_q.size()), 64'd0);
        chk("rst_mid_nodone", 64'(done_cnt - d0), 64'd0);
        kb = rand_key();
        build_model(kb);
        clear_log();
        start_at(0, kb, 1, n);
        wait_done("after_rst", 200);
        verify("after_rst", n);
        @(negedge clk);

        // Back-to-back schedules at N and N+74
        ka = rand_key();
        kb = rand_key();
        build_model(ka);
        clear_log();
        start_at(0, ka, 1, n);
        wait_done("b2b_a", 200);
        verify("b2b_a", n);
        build_model(kb);
        clear_log();
        while (cyc + 1 < n + 74) @(negedge clk);
        chk("b2b_ready_before", 64'(keys_ready), 64'd1);
        start_at(n + 74, kb, 1, nx);
        chk("b2b_start_edge", 64'(nx), 64'(n + 74));
        chk("b2b_ready_drop", 64'(keys_ready), 64'd0);
        wait_done("b2b_b", 200);
        verify("b2b_b", nx);
        chk("b2b_done_edge", 64'(done_edge), 64'(n + 147));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
